// File: rtl/div_seq_if.sv
// Request/response bundle for the sequential divider.
// Master issues operations; slave computes and returns results.
interface div_seq_if #(
  parameter int XLEN = 32
);
  logic            div_enable;
  logic [2:0]      div_op;
  logic [XLEN-1:0] div_rs1;
  logic [XLEN-1:0] div_rs2;
  logic            div_kill;
  logic            div_busy;
  logic            div_ready;
  logic [XLEN-1:0] div_result;

  modport master (
    output div_enable, div_op, div_rs1, div_rs2, div_kill,
    input  div_busy, div_ready, div_result
  );

  modport slave (
    input  div_enable, div_op, div_rs1, div_rs2, div_kill,
    output div_busy, div_ready, div_result
  );
endinterface

// File: rtl/div_seq.sv
// Iterative restoring divider for div/divu/rem/remu.
// One quotient bit per cycle; zero and overflow cases bypass CALC.
module div_seq #(
  parameter int XLEN = 32
) (
  input  logic     clock,
  input  logic     reset,
  div_seq_if.slave bus
);
  localparam int CW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIN
  } state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem, quo, dvs, result;
  logic            neg_quo, neg_rem, op_rem;

  logic            signed_op, is_rem, s1, s2;
  logic            dz, ovf, accept, last;
  logic [XLEN-1:0] mag1, mag2, special;
  logic [XLEN:0]   diff;
  logic            ge;
  logic [XLEN-1:0] rem_n, quo_n, final_val;

  always_comb begin
    signed_op = ~bus.div_op[0];
    is_rem    = bus.div_op[1];
    s1        = signed_op & bus.div_rs1[XLEN-1];
    s2        = signed_op & bus.div_rs2[XLEN-1];
    mag1      = s1 ? -bus.div_rs1 : bus.div_rs1;
    mag2      = s2 ? -bus.div_rs2 : bus.div_rs2;
    dz        = (bus.div_rs2 == '0);
    ovf       = signed_op & (bus.div_rs1 == MIN) &
                (bus.div_rs2 == '1);
    accept    = (state == IDLE) & bus.div_enable &
                bus.div_op[2] & ~bus.div_kill;
    if (dz)
      special = is_rem ? bus.div_rs1 : '1;
    else
      special = is_rem ? '0 : MIN;
  end

  // Restoring step: shift {rem,quo}, subtract if it fits
  always_comb begin
    diff  = {rem, quo[XLEN-1]} - {1'b0, dvs};
    ge    = ~diff[XLEN];
    rem_n = ge ? diff[XLEN-1:0]
               : {rem[XLEN-2:0], quo[XLEN-1]};
    quo_n = {quo[XLEN-2:0], ge};
    last  = (cnt == '0);
    if (op_rem)
      final_val = neg_rem ? -rem_n : rem_n;
    else
      final_val = neg_quo ? -quo_n : quo_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept)
          state_n = (dz | ovf) ? FIN : CALC;
      end
      CALC: begin
        if (last)
          state_n = FIN;
      end
      FIN: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (bus.div_kill)
      state_n = IDLE;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      rem     <= '0;
      quo     <= '0;
      dvs     <= '0;
      neg_quo <= 1'b0;
      neg_rem <= 1'b0;
      op_rem  <= 1'b0;
      result  <= '0;
    end else begin
      if (accept) begin
        cnt     <= CW'(XLEN-1);
        rem     <= '0;
        quo     <= mag1;
        dvs     <= mag2;
        neg_quo <= s1 ^ s2;
        neg_rem <= s1;
        op_rem  <= is_rem;
        if (dz | ovf)
          result <= special;
      end else if (state == CALC) begin
        cnt <= cnt - 1'b1;
        rem <= rem_n;
        quo <= quo_n;
        if (last & ~bus.div_kill)
          result <= final_val;
      end
    end
  end

  assign bus.div_busy   = (state != IDLE);
  assign bus.div_ready  = (state == FIN) & ~bus.div_kill;
  assign bus.div_result = result;
endmodule

// File: tb/tb_div_seq.sv
// Directed vector bench for div_seq: latency, results,
// kill, busy filtering, async reset and back-to-back ops.
module tb_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;

  div_seq_if #(.XLEN(32)) bus ();

  div_seq #(.XLEN(32)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          lat;
  } vec_t;

  localparam logic [2:0] DIV  = 3'b100;
  localparam logic [2:0] DIVU = 3'b101;
  localparam logic [2:0] REM  = 3'b110;
  localparam logic [2:0] REMU = 3'b111;

  vec_t vt[16];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  int          r_cyc, r_cnt;
  logic [31:0] r_res;
  logic        r_b1, r_bk, r_baft, r_dbl;

  // Cycle 0 is the acceptance cycle; window is inclusive
  task automatic run(input logic [2:0] op,
                     input logic [31:0] a,
                     input logic [31:0] b,
                     input int kill_at,
                     input int en_at,
                     input int win);
    logic prev;
    r_cyc = -1; r_cnt = 0; r_res = 'x;
    r_b1 = 1'bx; r_bk = 1'bx; r_baft = 1'bx;
    r_dbl = 1'b0; prev = 1'b0;
    for (int c = 0; c <= win; c++) begin
      @(negedge clk);
      bus.div_enable = (c == 0) || (c == en_at);
      bus.div_op     = (c == 0) ? op : DIVU;
      bus.div_rs1    = (c == 0) ? a : 32'd1;
      bus.div_rs2    = (c == 0) ? b : 32'd1;
      bus.div_kill   = (c == kill_at);
      #1;
      if (bus.div_ready) begin
        r_cnt++;
        if (r_cyc < 0) begin
          r_cyc = c;
          r_res = bus.div_result;
        end
        if (prev) r_dbl = 1'b1;
      end
      prev = bus.div_ready;
      if (c == 1) r_b1 = bus.div_busy;
      if (c == kill_at + 1) r_bk = bus.div_busy;
      if (r_cyc >= 0 && c == r_cyc + 1)
        r_baft = bus.div_busy;
    end
    bus.div_enable = 1'b0;
    bus.div_kill   = 1'b0;
  endtask

  initial begin
    vt[0]  = '{DIVU, 32'd100, 32'd7, 32'd14, 33};
    vt[1]  = '{REMU, 32'd100, 32'd7, 32'd2, 33};
    vt[2]  = '{REM, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE, 33};
    vt[3]  = '{DIV, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 33};
    vt[4]  = '{DIV, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 33};
    vt[5]  = '{REM, 32'd100, 32'hFFFFFFF9, 32'd2, 33};
    vt[6]  = '{DIVU, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 33};
    vt[7]  = '{REMU, 32'd7, 32'd100, 32'd7, 33};
    vt[8]  = '{DIV, 32'h80000000, 32'd2, 32'hC0000000, 33};
    vt[9]  = '{DIVU, 32'h80000000, 32'hFFFFFFFF, 32'd0, 33};
    vt[10] = '{REMU, 32'h80000000, 32'hFFFFFFFF,
               32'h80000000, 33};
    vt[11] = '{DIVU, 32'd55, 32'd0, 32'hFFFFFFFF, 1};
    vt[12] = '{REMU, 32'h1234, 32'd0, 32'h1234, 1};
    vt[13] = '{DIV, 32'h80000000, 32'hFFFFFFFF,
               32'h80000000, 1};
    vt[14] = '{REM, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1};
    vt[15] = '{REM, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 1};

    bus.div_enable = 1'b0;
    bus.div_op     = 3'b000;
    bus.div_rs1    = '0;
    bus.div_rs2    = '0;
    bus.div_kill   = 1'b0;

    #2;
    chk("rst_busy", 32'(bus.div_busy), 0);
    chk("rst_ready", 32'(bus.div_ready), 0);
    chk("rst_result", bus.div_result, 0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      run(vt[i].op, vt[i].a, vt[i].b, -10, -10, 40);
      chk($sformatf("v%0d_lat", i), r_cyc, vt[i].lat);
      chk($sformatf("v%0d_res", i), r_res, vt[i].res);
      chk($sformatf("v%0d_cnt", i), r_cnt, 1);
      chk($sformatf("v%0d_dbl", i), 32'(r_dbl), 0);
      chk($sformatf("v%0d_baft", i), 32'(r_baft), 0);
      if (vt[i].lat == 33)
        chk($sformatf("v%0d_b1", i), 32'(r_b1), 1);
    end

    // Kill mid-CALC, then a clean op
    run(DIVU, 32'd100, 32'd7, 10, -10, 40);
    chk("kill_busy", 32'(r_bk), 0);
    chk("kill_cnt", r_cnt, 0);
    run(DIVU, 32'd9, 32'd3, -10, -10, 40);
    chk("post_kill_lat", r_cyc, 33);
    chk("post_kill_res", r_res, 32'd3);

    // Kill in FIN suppresses that ready
    run(DIVU, 32'd50, 32'd5, 33, -10, 40);
    chk("killfin_cnt", r_cnt, 0);
    chk("killfin_busy", 32'(r_bk), 0);

    // Enable while busy is ignored
    run(DIVU, 32'd100, 32'd7, -10, 5, 40);
    chk("busy_en_cnt", r_cnt, 1);
    chk("busy_en_lat", r_cyc, 33);
    chk("busy_en_res", r_res, 32'd14);

    // Non-divide op and kill+enable are both filtered
    @(negedge clk);
    bus.div_enable = 1'b1;
    bus.div_op     = 3'b000;
    bus.div_rs1    = 32'd8;
    bus.div_rs2    = 32'd2;
    @(negedge clk);
    bus.div_enable = 1'b0;
    chk("op000_busy", 32'(bus.div_busy), 0);
    bus.div_enable = 1'b1;
    bus.div_op     = DIVU;
    bus.div_kill   = 1'b1;
    @(negedge clk);
    bus.div_enable = 1'b0;
    bus.div_kill   = 1'b0;
    chk("kill_en_busy", 32'(bus.div_busy), 0);
    @(negedge clk);
    chk("kill_en_busy2", 32'(bus.div_busy), 0);

    // Async reset mid-op; result was 14 before
    @(negedge clk);
    bus.div_enable = 1'b1;
    bus.div_op     = DIVU;
    bus.div_rs1    = 32'd1000;
    bus.div_rs2    = 32'd3;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      bus.div_enable = 1'b0;
    end
    chk("pre_rst_busy", 32'(bus.div_busy), 1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(bus.div_busy), 0);
    chk("arst_ready", 32'(bus.div_ready), 0);
    chk("arst_result", bus.div_result, 0);
    @(negedge clk);
    rst = 1'b0;
    begin
      int n;
      n = 0;
      for (int c = 0; c < 40; c++) begin
        @(negedge clk);
        if (bus.div_ready) n++;
      end
      chk("post_rst_cnt", n, 0);
    end

    // Back-to-back: second op accepted in cycle after FIN
    run(DIVU, 32'd21, 32'd4, -10, -10, 33);
    chk("b2b_a_lat", r_cyc, 33);
    chk("b2b_a_res", r_res, 32'd5);
    run(REMU, 32'd21, 32'd4, -10, -10, 40);
    chk("b2b_b_lat", r_cyc, 33);
    chk("b2b_b_res", r_res, 32'd1);
    chk("b2b_b_b1", 32'(r_b1), 1);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end
endmodule

// File: doc/div_seq.md
DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 Parameter: XLEN, default 32, operand/result width; only 32 is required to be supported.
REQ-002 Port: clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: div_enable  input  1  request strobe, sampled only in IDLE.
REQ-005 Port: div_op  input  3  funct code: div=100, divu=101, rem=110, remu=111.
REQ-006 Port: div_rs1  input  XLEN  dividend.
REQ-007 Port: div_rs2  input  XLEN  divisor.
REQ-008 Port: div_kill  input  1  pipeline flush; aborts any operation in progress.
REQ-009 Port: div_busy  output  1  high whenever the state is not IDLE.
REQ-010 Port: div_ready  output  1  one-cycle pulse; div_result is valid in that cycle.
REQ-011 Port: div_result  output  XLEN  quotient or remainder, selected by the latched op.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC and FIN.
REQ-013 A request SHALL be accepted only when the state is IDLE, div_enable=1, div_op[2]=1 and div_kill=0; op, rs1 and rs2 are latched on acceptance.
REQ-014 A request with div_op[2]=0 SHALL be ignored, and the FSM stays in IDLE.
REQ-015 div_enable while busy SHALL be ignored; no queuing.
REQ-016 Signed ops (div, rem): operands SHALL be converted to magnitudes at acceptance; quotient sign = sign(rs1) XOR sign(rs2); remainder sign = sign(rs1).
REQ-017 Normal path:
- IDLE -> CALC on acceptance; iteration counter loads XLEN-1.
- CALC performs one restoring step per cycle: shift {rem, quo} left; subtract the divisor magnitude if the result is non-negative; set the quotient bit.
- CALC -> FIN when the counter reaches 0, after exactly XLEN CALC cycles.
REQ-018 In FIN the FSM SHALL apply sign correction, drive div_result, pulse div_ready=1 and return to IDLE next cycle; latency is acceptance cycle + XLEN + 1, i.e. ready in cycle 33 when accepted in cycle 0.
REQ-019 Divide-by-zero (rs2=0): the FSM SHALL go directly IDLE -> FIN, with ready 1 cycle after acceptance.
- div/divu: result = all ones.
- rem/remu: result = rs1.
REQ-020 Signed overflow (div/rem with rs1=0x80000000 and rs2=0xFFFFFFFF): the FSM SHALL go directly IDLE -> FIN.
- div: result = 0x80000000.
- rem: result = 0.
REQ-021 div_kill=1 in any state SHALL force IDLE at the next edge with no div_ready pulse.
- Kill in FIN suppresses that cycle's ready.
- Kill in the same cycle as enable suppresses acceptance.
REQ-022 div_result SHALL hold its last value outside the ready cycle until the next FIN.
REQ-023 div_ready SHALL never be high for two consecutive cycles.
REQ-024 A new request SHALL be acceptable in the cycle after FIN (back-to-back throughput of 1 op per XLEN+2 cycles).

Reset
REQ-025 While reset=1, asynchronously: state = IDLE, counter = 0, div_busy = 0, div_ready = 0, div_result = 0, and all internal operand registers = 0.
REQ-026 Reset asserted mid-CALC SHALL abandon the operation; after release, no ready pulse occurs and the next accepted request behaves normally.

Verification
REQ-027 divu, rs1=100, rs2=7 -> busy from cycle 1; ready only in cycle 33; result=14; busy=0 in cycle 34.
REQ-028 Signed cases, each result with ready in cycle 33:
- rem, rs1=0xFFFFFF9C (-100), rs2=7 -> 0xFFFFFFFE (-2).
- div, same operands -> 0xFFFFFFF2 (-14).
REQ-029 Special cases, each with ready in cycle 1:
- divu, rs2=0 -> 0xFFFFFFFF.
- remu, rs1=0x1234, rs2=0 -> 0x1234.
- div, 0x80000000 / 0xFFFFFFFF -> 0x80000000.
REQ-030 Start divu 100/7, assert div_kill in cycle 10 -> busy=0 in cycle 11; no ready pulse through cycle 40; then a new divu 9/3 -> result 3 with ready 33 cycles after its acceptance.
REQ-031 Busy and idle-filter checks:
- div_enable pulsed in cycle 5 of an active op -> ignored; exactly one ready pulse.
- div_op=000 with div_enable=1 in IDLE -> busy stays 0.
REQ-032 Assert reset in cycle 15 of an op -> busy, ready and result = 0 immediately (asynchronously, not at the next edge); no ready pulse after release.
